// File: rtl/result_uart_reporter.sv
// result_uart_reporter: sends a result value as uppercase ASCII hex plus CR LF over an 8N1 UART.
// A request that arrives while a message is in flight is held, one deep, with the latest value kept.
module result_uart_reporter #(
  parameter int clk_freq       = 50000000,
  parameter int uart_baud_rate = 57600,
  parameter int p_N            = 16,
  parameter int p_AUTO         = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [p_N-1:0] i_data,
  input  logic           i_send,
  output logic           o_busy,
  output logic           o_done,
  output logic           uart_txd
);
  localparam int DIV = clk_freq / uart_baud_rate;
  localparam int NDIG = p_N / 4;
  localparam int BW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(NDIG + 2);
  localparam logic [BW-1:0] BMAX = BW'(DIV - 1);
  localparam logic [CW-1:0] CR_IDX = CW'(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [p_N-1:0] src_q, src_d, hold_q, hold_d, last_q;
  logic           pend_q, pend_d;
  logic           req, tick;
  logic [3:0]     nib;
  logic [7:0]     ch;

  assign req = i_send | ((p_AUTO != 0) && (i_data != last_q));
  assign tick = baud_q == BMAX;
  // Digits are taken MSB-first; indices past the last digit select CR then LF.
  assign nib = 4'(src_q >> (p_N - 4 - 4 * int'(idx_q)));
  assign ch = idx_q == CR_IDX ? 8'h0D :
              idx_q == LAST ? 8'h0A :
              nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
  assign uart_txd = state_q == START ? 1'b0 : state_q == DATA ? ch[bit_q] : 1'b1;
  assign o_done = state_q == STOP && tick && idx_q == LAST;
  assign o_busy = state_q != IDLE || pend_q;

  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    idx_d = idx_q;
    src_d = src_q;
    hold_d = (req && state_q != IDLE) ? i_data : hold_q;
    pend_d = pend_q | (req && state_q != IDLE);
    case (state_q)
      IDLE: if (req) begin
        state_d = START;
        idx_d = '0;
        src_d = i_data;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (tick) begin
        bit_d = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        if (idx_q != LAST) begin
          state_d = START;
          idx_d = idx_q + 1'b1;
        end else begin
          // A request landing on the completion edge is served as the next message.
          state_d = (pend_q || req) ? START : IDLE;
          idx_d = '0;
          src_d = req ? i_data : hold_q;
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      idx_q <= '0;
      src_q <= '0;
      hold_q <= '0;
      pend_q <= 1'b0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      idx_q <= idx_d;
      src_q <= src_d;
      hold_q <= hold_d;
      pend_q <= pend_d;
      last_q <= i_data;
    end
  end
endmodule

// File: tb/tb_result_uart_reporter.sv
// tb_result_uart_reporter: directed checks of the hex UART reporter at DIV=4, with and without auto-send.
module tb_result_uart_reporter;
  logic clk = 1'b0;
  logic rst, send1, sel;
  logic [15:0] data1, data2;
  logic busy1, done1, txd1, busy2, done2, txd2;
  logic mtxd, mdone;
  int cyc, checks, errors, rph, done_cnt;
  logic [7:0] rsh;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  result_uart_reporter #(.clk_freq(16), .uart_baud_rate(4), .p_N(16), .p_AUTO(0)) dut (
    .clk(clk), .rst(rst), .i_data(data1), .i_send(send1),
    .o_busy(busy1), .o_done(done1), .uart_txd(txd1)
  );

  result_uart_reporter #(.clk_freq(16), .uart_baud_rate(4), .p_N(16), .p_AUTO(1)) dut_auto (
    .clk(clk), .rst(rst), .i_data(data2), .i_send(1'b0),
    .o_busy(busy2), .o_done(done2), .uart_txd(txd2)
  );

  assign mtxd = sel ? txd2 : txd1;
  assign mdone = sel ? done2 : done1;

  // Receiver: rph is the cycle offset from the first low cycle of a start bit; bits sampled mid-cell.
  initial rph = -1;
  always @(negedge clk) begin
    if (rst) rph = -1;
    else if (rph < 0) begin
      if (!mtxd) rph = 1;
    end else begin
      if (rph >= 5 && rph <= 33 && (rph - 5) % 4 == 0) rsh[3'((rph - 5) / 4)] = mtxd;
      if (rph == 37) begin
        rxq.push_back(mtxd ? rsh : 8'hEE);
        rph = -1;
      end else rph++;
    end
    if (mdone) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, output int t0);
    @(negedge clk);
    data1 = d;
    send1 = 1'b1;
    @(negedge clk);
    send1 = 1'b0;
    t0 = cyc;
    chk("start_low", 32'(txd1), 0);
    chk("busy_on", 32'(busy1), 1);
  endtask

  task automatic wait_done(output int t);
    for (int i = 0; i < 400 && !mdone; i++) @(negedge clk);
    chk("done_seen", 32'(mdone), 1);
    t = cyc;
  endtask

  task automatic check_msg(input string tag, input logic [47:0] exp);
    logic [7:0] b;
    chk({tag, "_len"}, 32'(rxq.size() >= 6), 1);
    for (int i = 0; i < 6; i++) begin
      b = rxq.size() > 0 ? rxq.pop_front() : 8'hFF;
      chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[47 - 8 * i -: 8]));
    end
  endtask

  initial begin
    int t0, t1, t, bad, dc;
    checks = 0; errors = 0; done_cnt = 0;
    rst = 1'b1; send1 = 1'b0; sel = 1'b0; data1 = '0; data2 = '0;
    repeat (5) @(negedge clk);
    chk("rst_txd", 32'(txd1), 1);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_txd_auto", 32'(txd2), 1);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || txd2 !== 1'b1 || busy2 !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);

    // o_done falls on the 240th message cycle, i.e. 239 cycles after the first START cycle.
    send(16'h1234, t0);
    wait_done(t);
    chk("latency_1234", 32'(t - t0), 239);
    @(negedge clk);
    chk("done_pulse", 32'(done1), 0);
    chk("busy_off", 32'(busy1), 0);
    chk("txd_idle", 32'(txd1), 1);
    check_msg("m1234", {"1234", 8'h0D, 8'h0A});

    send(16'hABCF, t0);
    wait_done(t);
    chk("latency_abcf", 32'(t - t0), 239);
    @(negedge clk);
    check_msg("mABCF", {"ABCF", 8'h0D, 8'h0A});
    send(16'h0000, t0);
    wait_done(t);
    @(negedge clk);
    check_msg("m0000", {"0000", 8'h0D, 8'h0A});

    dc = done_cnt;
    send(16'h0001, t0);
    repeat (50) @(negedge clk);
    data1 = 16'h0002; send1 = 1'b1;
    @(negedge clk);
    send1 = 1'b0;
    repeat (30) @(negedge clk);
    data1 = 16'h0003; send1 = 1'b1;
    @(negedge clk);
    send1 = 1'b0;
    wait_done(t1);
    chk("latency_0001", 32'(t1 - t0), 239);
    @(negedge clk);
    chk("b2b_busy", 32'(busy1), 1);
    chk("b2b_start", 32'(txd1), 0);
    t0 = cyc;
    wait_done(t);
    chk("latency_0003", 32'(t - t0), 239);
    @(negedge clk);
    chk("b2b_busy_off", 32'(busy1), 0);
    check_msg("m0001", {"0001", 8'h0D, 8'h0A});
    check_msg("m0003", {"0003", 8'h0D, 8'h0A});
    repeat (200) @(negedge clk);
    chk("queue_one_deep", 32'(rxq.size()), 0);
    chk("b2b_done_count", 32'(done_cnt - dc), 2);

    // Second character starts 40 cycles in; its data bit 3 spans offsets 56..59.
    send(16'h1234, t0);
    repeat (57) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_txd", 32'(txd1), 1);
    chk("rst_mid_busy", 32'(busy1), 0);
    chk("rst_mid_done", 32'(done1), 0);
    rst = 1'b0;
    rxq.delete();
    dc = done_cnt;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0) bad++;
    end
    chk("rst_no_resume", 32'(bad), 0);
    chk("rst_no_done", 32'(done_cnt - dc), 0);
    chk("rst_no_bytes", 32'(rxq.size()), 0);

    sel = 1'b1;
    @(negedge clk);
    data2 = 16'h00FF;
    @(negedge clk);
    chk("auto_start", 32'(txd2), 0);
    chk("auto_busy", 32'(busy2), 1);
    t0 = cyc;
    wait_done(t);
    chk("latency_auto", 32'(t - t0), 239);
    @(negedge clk);
    check_msg("m00FF", {"00FF", 8'h0D, 8'h0A});
    dc = done_cnt;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (txd2 !== 1'b1 || busy2 !== 1'b0) bad++;
    end
    chk("auto_stable", 32'(bad), 0);
    chk("auto_no_done", 32'(done_cnt - dc), 0);
    chk("auto_no_bytes", 32'(rxq.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
